rr_arb_mux_4: RTL and testbench

- Round-robin arbiter that shares one 4:1 data mux and one output register among four valid/ready requesters.
- Selects one winner per cycle, drives the mux select from the grant and registers the selected word into a single-entry output stage.
- Sits between four producer channels and one shared downstream consumer in the combinational-logic exercise datapaths.

---
 rtl/rr_arb_mux_4.sv | 147 ++++++++++++++
 tb/tb_rr_arb_mux_4.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux_4.sv
// rr_arb_mux_4 -- round-robin arbiter sharing one 4:1 data mux and one output
// register among four valid/ready requesters.
//
// One requester wins per cycle. The grant index drives the mux select, and the
// selected word is registered into a single-entry output stage. A two-state FSM
// (EMPTY/FULL) tracks that stage. The stage can take a new word when it is empty,
// or when it is being drained in the same cycle. This keeps throughput at one
// word per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   [3:0]     per-requester valid
//   in_data    [4*W-1:0] requester words, requester i at [i*W +: W]
//   in_ready   [3:0]     per-requester ready (combinational, one-hot or zero)
//   out_valid            output stage holds a word
//   out_data   [W-1:0]   registered selected word
//   out_ready            downstream accepts out_data
//   out_id     [1:0]     registered winner index (only with RR_ARB_MUX_4_OUT_ID_EN)
//   grant_sel  [1:0]     combinational winner index, 0 when nothing requests
//
// Optional feature: define RR_ARB_MUX_4_OUT_ID_EN to add the out_id port and
// its register.

// Per-requester ready slice: requester IDX is ready only when it is the winner
// and the output stage can load.
module rr_arb_mux_4_lane #(
   parameter logic [1:0] IDX = 2'd0
) (
   input  logic       can_load,
   input  logic       any_req,
   input  logic [1:0] grant_sel,
   output logic       ready
);
   assign ready = can_load & any_req & (grant_sel == IDX);
endmodule

module rr_arb_mux_4 #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [3:0]     in_valid,
   input  logic [4*W-1:0] in_data,
   output logic [3:0]     in_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   input  logic           out_ready,
`ifdef RR_ARB_MUX_4_OUT_ID_EN
   output logic [1:0]     out_id,
`endif
   output logic [1:0]     grant_sel
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t         state, state_nxt;
   logic [1:0]     last_ptr;
   logic [W-1:0]   data_q;
   logic [W-1:0]   sel_data;
   logic [3:0]     lane_rdy;
   logic [1:0]     idx;
   logic           found;
   logic           any_req;
   logic           can_load;
   logic           accept;
   logic           drain;

   assign any_req  = |in_valid;
   assign can_load = (state == EMPTY) | out_ready;

   // Rotating priority search: start at last_ptr+1 and finish at last_ptr
   // itself. The 2-bit adds wrap 3 -> 0 naturally.
   always_comb begin
      grant_sel = 2'd0;
      found     = 1'b0;
      idx       = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_ptr + 2'(k);
         if (!found && in_valid[idx]) begin
            grant_sel = idx;
            found     = 1'b1;
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_lane
         rr_arb_mux_4_lane #(.IDX(2'(g))) u_lane (
            .can_load  (can_load),
            .any_req   (any_req),
            .grant_sel (grant_sel),
            .ready     (lane_rdy[g])
         );
      end
   endgenerate

   // While reset is held the state reads EMPTY, which would make can_load high.
   // Gate in_ready here so no requester sees a handshake during reset.
   assign in_ready = rst_n ? lane_rdy : 4'b0000;
   assign accept   = |(in_valid & in_ready);
   assign drain    = (state == FULL) & out_ready;

   // Shared 4:1 data mux, selected by the grant.
   assign sel_data = in_data[grant_sel*W +: W];

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (accept) state_nxt = FULL;
         FULL:    if (drain && !accept) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         last_ptr <= 2'd3;
         data_q   <= '0;
      end else begin
         state <= state_nxt;
         // The pointer moves only on an accept, so draining or idling leaves
         // the priority order unchanged. A drain does not change the data.
         if (accept) begin
            data_q   <= sel_data;
            last_ptr <= grant_sel;
         end
      end
   end

   assign out_valid = (state == FULL);
   assign out_data  = data_q;

`ifdef RR_ARB_MUX_4_OUT_ID_EN
   logic [1:0] id_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      id_q <= 2'd0;
      else if (accept) id_q <= grant_sel;
   end

   assign out_id = id_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux_4.sv
module tb_rr_arb_mux_4;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [3:0]     in_valid = '0;
   logic [4*W-1:0] in_data = '0;
   logic [3:0]     in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_ready = 1'b0;
   logic [1:0]     grant_sel;
`ifdef RR_ARB_MUX_4_OUT_ID_EN
   logic [1:0]     out_id;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   rr_arb_mux_4 #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
`ifdef RR_ARB_MUX_4_OUT_ID_EN
      .out_id    (out_id),
`endif
      .grant_sel (grant_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one stored word plus the index of the last winner.
   int         m_last = 3;
   bit         m_full = 0;
   logic [W-1:0] m_data = '0;
   int         m_id = 0;

   function automatic int m_winner(input int last, input logic [3:0] v);
      for (int k = 1; k <= 4; k++)
         if (v[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_full <= 0; m_data <= '0; m_last <= 3; m_id <= 0;
      end else begin
         int w;
         w = m_winner(m_last, in_valid);
         if (w >= 0 && (!m_full || out_ready)) begin
            m_full <= 1;
            m_data <= in_data[w*W +: W];
            m_last <= w;
            m_id   <= w;
         end else if (m_full && out_ready) begin
            m_full <= 0;
         end
      end
   end

   // Compare process: checks the DUT against the model away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         int w;
         logic [3:0] er;
         w  = m_winner(m_last, in_valid);
         er = (w >= 0 && (!m_full || out_ready)) ? 4'(1 << w) : 4'b0000;
         check("model_grant_sel", 32'(grant_sel), (w >= 0) ? 32'(w) : 32'd0);
         check("model_in_ready", 32'(in_ready), 32'(er));
         check("model_out_valid", 32'(out_valid), 32'(m_full));
         if (m_full) check("model_out_data", 32'(out_data), 32'(m_data));
`ifdef RR_ARB_MUX_4_OUT_ID_EN
         check("model_out_id", 32'(out_id), 32'(m_id));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] seq1 [5];
      int           ids1 [5];
      seq1 = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
      ids1 = '{0, 1, 2, 3, 0};

      // Reset state
      #2;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data", 32'(out_data), 32'd0);
      in_valid = 4'b1111;
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd0);
      in_valid = 4'b0000;
      step();
      step();
      rst_n = 1'b1;

      // All four requesting: grant order is A,B,C,D,A with no gaps.
      in_data   = 16'hDCBA;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      #1;
      check("s1_first_grant", 32'(grant_sel), 32'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("s1_out_valid", 32'(out_valid), 32'd1);
         check("s1_out_data", 32'(out_data), 32'(seq1[k]));
`ifdef RR_ARB_MUX_4_OUT_ID_EN
         check("s1_out_id", 32'(out_id), 32'(ids1[k]));
`else
         if (ids1[k] < 0) check("s1_unreachable", 32'(ids1[k]), 32'd0);
`endif
      end

      // Drain to empty.
      in_valid = 4'b0000;
      #1;
      check("idle_grant_sel", 32'(grant_sel), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      step();
      check("drain_out_valid", 32'(out_valid), 32'd0);
      check("drain_out_data_hold", 32'(out_data), 32'hA);

      // Single persistent requester 2.
      in_valid = 4'b0100;
      for (int k = 0; k < 5; k++) begin
         in_data = 16'(k + 1) << 8;
         #1;
         check("s2_in_ready", 32'(in_ready), 32'b0100);
         check("s2_grant_sel", 32'(grant_sel), 32'd2);
         step();
         check("s2_out_valid", 32'(out_valid), 32'd1);
         check("s2_out_data", 32'(out_data), 32'(k + 1));
      end

      // Load requester 1, then stall with everyone requesting.
      in_data  = 16'hDCBA;
      in_valid = 4'b0010;
      step();
      check("s3_load", 32'(out_data), 32'hB);
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("s3_stall_ready", 32'(in_ready), 32'd0);
         step();
         check("s3_stall_valid", 32'(out_valid), 32'd1);
         check("s3_stall_data", 32'(out_data), 32'hB);
      end
      out_ready = 1'b1;
      #1;
      check("s3_resume_grant", 32'(grant_sel), 32'd2);
      step();
      check("s3_resume_data", 32'(out_data), 32'hC);

      // Requester 3, then wrap-around to 0, then back to 3.
      in_valid = 4'b1000;
      step();
      check("s4_req3", 32'(out_data), 32'hD);
      in_valid = 4'b1001;
      step();
      check("s4_wrap0", 32'(out_data), 32'hA);
      step();
      check("s4_then3", 32'(out_data), 32'hD);

      // Stall with no requests: the output stage holds its word.
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      step();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'hD);

      // Asynchronous reset in the middle of a cycle while FULL.
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_data", 32'(out_data), 32'd0);
      @(negedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 4'b1010;
      #1;
      check("s5_first_grant", 32'(grant_sel), 32'd1);
      step();
      check("s5_first_data", 32'(out_data), 32'hB);
      step();
      check("s5_second_data", 32'(out_data), 32'hD);

      in_valid = 4'b0000;
      step();
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
